// File: rtl/esc_seq_tx.sv
// Escape-sequence transmitter: encodes mode changes as ESC+code and stuffs literal ESC bytes
// as ESC ESC. It also tracks the mode the far-end decoder will end up in.
module esc_seq_tx #(
  parameter logic [7:0] ESC_CHAR  = 8'h1B,
  parameter logic [7:0] CODE_BASE = 8'h30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       mode_req_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] cur_mode
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MODE_CODE = 2'd1,
    ST_LIT_ESC   = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF = 2'd0;

  // A code byte equal to ESC would be mistaken for stuffing, and CODE_BASE+3 must not overflow.
  if ((CODE_BASE == ESC_CHAR) || ((CODE_BASE + 8'd1) == ESC_CHAR) ||
      ((CODE_BASE + 8'd2) == ESC_CHAR) || ((CODE_BASE + 8'd3) == ESC_CHAR) ||
      (CODE_BASE > 8'hFC)) begin : g_bad_code_base
    $error("esc_seq_tx: CODE_BASE..CODE_BASE+3 collides with ESC_CHAR or overflows");
  end

  state_t     state_q;
  logic [7:0] out_data_q;
  logic       out_valid_q;
  logic [1:0] cur_mode_q;
  logic [1:0] pending_q;
  logic       load_ok_s;
  logic       idle_s;

  assign load_ok_s      = !out_valid_q || out_ready;
  assign idle_s         = (state_q == ST_IDLE);
  assign mode_req_ready = idle_s && load_ok_s;
  assign in_ready       = idle_s && load_ok_s && !mode_req_valid;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign cur_mode  = cur_mode_q;

  // Sequencer and output register. A load in the same cycle overrides the post-transfer clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      cur_mode_q  <= MODE_OFF;
      pending_q   <= MODE_OFF;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (mode_req_valid && load_ok_s) begin
            if (mode_req != cur_mode_q) begin
              out_data_q  <= ESC_CHAR;
              out_valid_q <= 1'b1;
              pending_q   <= mode_req;
              state_q     <= ST_MODE_CODE;
            end
          end else if (in_valid && load_ok_s) begin
            if (cur_mode_q != MODE_OFF) begin
              out_data_q  <= in_data;
              out_valid_q <= 1'b1;
              if (in_data == ESC_CHAR) begin
                state_q <= ST_LIT_ESC;
              end
            end
          end
        end
        ST_MODE_CODE: begin
          if (load_ok_s) begin
            out_data_q  <= CODE_BASE + {6'd0, pending_q};
            out_valid_q <= 1'b1;
            cur_mode_q  <= pending_q;
            state_q     <= ST_IDLE;
          end
        end
        ST_LIT_ESC: begin
          if (load_ok_s) begin
            out_data_q  <= ESC_CHAR;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
